// File: rtl/umips_pkg.sv
// Shared definitions for the umips pipeline control blocks: forwarding
// select encodings and register address width.
package umips_pkg;

  localparam int REG_AW = 5;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_WB  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;

endpackage : umips_pkg

// File: rtl/umips_muldiv_timer.sv
// HI/LO unit occupancy timer: loads MUL_CYCLES or DIV_CYCLES on a start
// pulse and counts down to idle; busy while the count is non-zero.
module umips_muldiv_timer #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_start,
  input  logic i_is_div,
  output logic o_busy
);

  localparam int CW = $clog2(DIV_CYCLES + 1);

  logic [CW-1:0] r_cnt;

  // Countdown with reload; a start while busy simply reloads.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= {CW{1'b0}};
    end else if (i_start) begin
      r_cnt <= i_is_div ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
    end else if (r_cnt != {CW{1'b0}}) begin
      r_cnt <= r_cnt - CW'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_busy = (r_cnt != {CW{1'b0}});

endmodule : umips_muldiv_timer

// File: rtl/umips_hazard_unit.sv
// Hazard/forwarding controller for the 5-stage umips core.
// Optional stall-cycle performance counter: define UMIPS_HAZ_PERF_CNT_EN.
module umips_hazard_unit
  import umips_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_hilo_read,
  input  logic              id_muldiv,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_regwrite,
  input  logic              ex_memtoreg,
  input  logic              ex_muldiv_start,
  input  logic              ex_is_div,
  input  logic              ex_branch_taken,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_regwrite,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic [1:0]        ex_fwd_a,
  output logic [1:0]        ex_fwd_b,
  output logic              muldiv_busy,
  output logic [31:0]       stall_cycles
);

  // The EX producer is newer than the MEM producer, so it wins; $0 never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] src,
    input logic              uses,
    input logic [REG_AW-1:0] exr,
    input logic              exw,
    input logic [REG_AW-1:0] memr,
    input logic              memw
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (uses && exw && (exr != {REG_AW{1'b0}}) && (exr == src)) begin
      sel = FWD_MEM;
    end else if (uses && memw && (memr != {REG_AW{1'b0}}) && (memr == src)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

  logic       w_busy;
  logic       w_load_use;
  logic       w_hilo_stall;
  logic       w_stall;
  logic       w_idex_flush;
  logic [1:0] w_fwd_a_next;
  logic [1:0] w_fwd_b_next;
  logic [1:0] r_fwd_a;
  logic [1:0] r_fwd_b;

  umips_muldiv_timer #(
    .MUL_CYCLES(MUL_CYCLES),
    .DIV_CYCLES(DIV_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (ex_muldiv_start),
    .i_is_div(ex_is_div),
    .o_busy  (w_busy)
  );

  // Stall detection and forward-select computation for the ID instruction.
  always_comb begin
    w_load_use   = 1'b0;
    w_hilo_stall = 1'b0;
    w_fwd_a_next = FWD_RF;
    w_fwd_b_next = FWD_RF;
    w_load_use   = ex_memtoreg && ex_regwrite && (ex_rd != {REG_AW{1'b0}}) &&
                   ((id_uses_rs && (ex_rd == id_rs)) || (id_uses_rt && (ex_rd == id_rt)));
    w_hilo_stall = (id_hilo_read || id_muldiv) && (w_busy || ex_muldiv_start);
    w_fwd_a_next = fwd_sel(id_rs, id_uses_rs, ex_rd, ex_regwrite, mem_rd, mem_regwrite);
    w_fwd_b_next = fwd_sel(id_rt, id_uses_rt, ex_rd, ex_regwrite, mem_rd, mem_regwrite);
  end

  assign w_stall      = w_load_use || w_hilo_stall;
  assign w_idex_flush = ex_branch_taken || w_stall;

  // Forward selects travel with the ID/EX register; a bubble carries no forwarding.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fwd_a <= FWD_RF;
      r_fwd_b <= FWD_RF;
    end else if (w_idex_flush) begin
      r_fwd_a <= FWD_RF;
      r_fwd_b <= FWD_RF;
    end else begin
      r_fwd_a <= w_fwd_a_next;
      r_fwd_b <= w_fwd_b_next;
    end
  end

`ifdef UMIPS_HAZ_PERF_CNT_EN
  logic [31:0] r_stall_cycles;

  // Saturating count of cycles lost to stalls not superseded by a branch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cycles <= 32'd0;
    end else if (w_stall && !ex_branch_taken && (r_stall_cycles != 32'hFFFF_FFFF)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end else begin
      r_stall_cycles <= r_stall_cycles;
    end
  end

  assign stall_cycles = r_stall_cycles;
`else
  assign stall_cycles = 32'd0;
`endif

  assign pc_en       = !w_stall || ex_branch_taken;
  assign ifid_en     = !w_stall || ex_branch_taken;
  assign ifid_flush  = ex_branch_taken;
  assign idex_flush  = w_idex_flush;
  assign ex_fwd_a    = r_fwd_a;
  assign ex_fwd_b    = r_fwd_b;
  assign muldiv_busy = w_busy;

endmodule : umips_hazard_unit

// File: tb/tb_umips_hazard_unit.sv
// Self-checking bench for umips_hazard_unit: behavioural model with a
// scoreboard queue of post-edge expectations plus directed scenario checks.
module tb_umips_hazard_unit;

  localparam int MULC = 4;
  localparam int DIVC = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rs, id_rt, ex_rd, mem_rd;
  logic        id_uses_rs, id_uses_rt, id_hilo_read, id_muldiv;
  logic        ex_regwrite, ex_memtoreg, ex_muldiv_start, ex_is_div, ex_branch_taken;
  logic        mem_regwrite;
  logic        pc_en, ifid_en, ifid_flush, idex_flush, muldiv_busy;
  logic [1:0]  ex_fwd_a, ex_fwd_b;
  logic [31:0] stall_cycles;

  umips_hazard_unit #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_hilo_read(id_hilo_read), .id_muldiv(id_muldiv),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg),
    .ex_muldiv_start(ex_muldiv_start), .ex_is_div(ex_is_div),
    .ex_branch_taken(ex_branch_taken),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b), .muldiv_busy(muldiv_busy),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        busy;
    logic [31:0] sc;
  } exp_t;

  exp_t sb_q[$];

  int          n_err = 0;
  int          n_chk = 0;
  int          m_cnt = 0;
  logic [1:0]  m_fa = 2'd0;
  logic [1:0]  m_fb = 2'd0;
  logic [31:0] m_sc = 32'd0;
  logic        g_pc_en;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] r, input logic u);
    if (!u || r == 5'd0) return 2'd0;
    if (ex_regwrite && ex_rd == r) return 2'd2;
    if (mem_regwrite && mem_rd == r) return 2'd1;
    return 2'd0;
  endfunction

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    id_hilo_read = 1'b0; id_muldiv = 1'b0;
    ex_rd = 5'd0; ex_regwrite = 1'b0; ex_memtoreg = 1'b0;
    ex_muldiv_start = 1'b0; ex_is_div = 1'b0; ex_branch_taken = 1'b0;
    mem_rd = 5'd0; mem_regwrite = 1'b0;
  endtask

  // One clock: check combinational outputs, queue and check post-edge state.
  task automatic step();
    logic lu, hs, st, busy;
    exp_t e, got_e;
    int   cnt_n;
    #1;
    busy = (m_cnt != 0);
    lu = ex_memtoreg && ex_regwrite && ex_rd != 5'd0 &&
         ((id_uses_rs && ex_rd == id_rs) || (id_uses_rt && ex_rd == id_rt));
    hs = (id_hilo_read || id_muldiv) && (busy || ex_muldiv_start);
    st = lu || hs;
    g_pc_en = pc_en;
    if (rst_n) begin
      chk("pc_en", pc_en, !st || ex_branch_taken);
      chk("ifid_en", ifid_en, !st || ex_branch_taken);
      chk("ifid_flush", ifid_flush, ex_branch_taken);
      chk("idex_flush", idex_flush, st || ex_branch_taken);
      chk("busy_pre", muldiv_busy, busy);
    end
    if (ex_muldiv_start) cnt_n = ex_is_div ? DIVC : MULC;
    else if (m_cnt > 0)  cnt_n = m_cnt - 1;
    else                 cnt_n = 0;
    if (!rst_n) begin
      e = '{fa: 2'd0, fb: 2'd0, busy: 1'b0, sc: 32'd0};
      cnt_n = 0;
    end else begin
      e.fa = (st || ex_branch_taken) ? 2'd0 : ref_fwd(id_rs, id_uses_rs);
      e.fb = (st || ex_branch_taken) ? 2'd0 : ref_fwd(id_rt, id_uses_rt);
      e.busy = (cnt_n != 0);
`ifdef UMIPS_HAZ_PERF_CNT_EN
      e.sc = (st && !ex_branch_taken && m_sc != 32'hFFFF_FFFF) ? m_sc + 32'd1 : m_sc;
`else
      e.sc = 32'd0;
`endif
    end
    sb_q.push_back(e);
    m_cnt = cnt_n; m_fa = e.fa; m_fb = e.fb; m_sc = e.sc;
    @(posedge clk);
    #1;
    got_e = sb_q.pop_front();
    chk("ex_fwd_a", ex_fwd_a, got_e.fa);
    chk("ex_fwd_b", ex_fwd_b, got_e.fb);
    chk("muldiv_busy", muldiv_busy, got_e.busy);
    chk("stall_cycles", stall_cycles, got_e.sc);
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int stalls;
    idle();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    do_reset();
    chk("rst_fwd_a", ex_fwd_a, 2'd0);
    chk("rst_busy", muldiv_busy, 1'b0);

    // Forward from EX
    idle(); ex_rd = 5'd3; ex_regwrite = 1'b1; id_rs = 5'd3; id_uses_rs = 1'b1;
    id_rt = 5'd4; id_uses_rt = 1'b1;
    step();
    chk("exfwd_a", ex_fwd_a, 2'd2);
    chk("exfwd_b", ex_fwd_b, 2'd0);
    chk("exfwd_pc_en", g_pc_en, 1'b1);

    // Load-use then WB forward
    idle(); ex_rd = 5'd5; ex_regwrite = 1'b1; ex_memtoreg = 1'b1; id_rt = 5'd5; id_uses_rt = 1'b1;
    step();
    chk("lu_pc_en", g_pc_en, 1'b0);
    idle(); mem_rd = 5'd5; mem_regwrite = 1'b1; id_rt = 5'd5; id_uses_rt = 1'b1;
    step();
    chk("lu_pc_en_after", g_pc_en, 1'b1);
    chk("lu_fwd_b_wb", ex_fwd_b, 2'd1);

    // $0 never matches; EX beats MEM
    idle(); ex_rd = 5'd0; ex_regwrite = 1'b1; id_rs = 5'd0; id_uses_rs = 1'b1;
    mem_regwrite = 1'b1; mem_rd = 5'd0;
    step();
    chk("zero_fwd_a", ex_fwd_a, 2'd0);
    idle(); ex_rd = 5'd7; ex_regwrite = 1'b1; mem_rd = 5'd7; mem_regwrite = 1'b1;
    id_rs = 5'd7; id_uses_rs = 1'b1;
    step();
    chk("prio_fwd_a", ex_fwd_a, 2'd2);

    // Divide occupancy
    do_reset();
    stalls = 0;
    idle(); ex_muldiv_start = 1'b1; ex_is_div = 1'b1; id_hilo_read = 1'b1;
    step();
    if (!g_pc_en) stalls++;
    for (int i = 0; i < DIVC + 2; i++) begin
      idle(); id_hilo_read = 1'b1;
      step();
      if (!g_pc_en) stalls++;
    end
    chk("div_stall_len", stalls, 33);
    chk("div_busy_end", muldiv_busy, 1'b0);
`ifdef UMIPS_HAZ_PERF_CNT_EN
    chk("div_stall_cycles", stall_cycles, 32'd33);
`endif

    // Branch during load-use stall
    idle(); ex_rd = 5'd9; ex_regwrite = 1'b1; ex_memtoreg = 1'b1; id_rs = 5'd9; id_uses_rs = 1'b1;
    mem_rd = 5'd9; mem_regwrite = 1'b1; ex_branch_taken = 1'b1;
    step();
    chk("br_pc_en", g_pc_en, 1'b1);
    chk("br_fwd_a", ex_fwd_a, 2'd0);

    // Reset mid-divide
    idle(); ex_muldiv_start = 1'b1; ex_is_div = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin idle(); step(); end
    do_reset();
    chk("rstdiv_busy", muldiv_busy, 1'b0);
    chk("rstdiv_sc", stall_cycles, 32'd0);
    idle(); id_hilo_read = 1'b1;
    step();
    chk("rstdiv_pc_en", g_pc_en, 1'b1);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      id_uses_rs = 1'($urandom); id_uses_rt = 1'($urandom);
      id_hilo_read = ($urandom_range(0, 7) == 0); id_muldiv = ($urandom_range(0, 7) == 0);
      ex_rd = 5'($urandom_range(0, 3)); ex_regwrite = 1'($urandom);
      ex_memtoreg = 1'($urandom);
      ex_muldiv_start = ($urandom_range(0, 15) == 0); ex_is_div = 1'($urandom);
      ex_branch_taken = ($urandom_range(0, 7) == 0);
      mem_rd = 5'($urandom_range(0, 3)); mem_regwrite = 1'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_umips_hazard_unit

// File: doc/umips_hazard_unit.md
Name: umips_hazard_unit

Overview:
- Pipeline hazard/forwarding controller for the 5-stage core.
- Produces the registered 2-bit forwarding selects that drive the EX-stage operand mux3 selects.
- Also produces the stall/flush enables for the PC, IF/ID and ID/EX registers.
- Tracks multi-cycle mult/div occupancy, so HI/LO readers and new mult/div instructions stall until the result is ready.

Parameters:
MUL_CYCLES, 4, cycles a mult/multu occupies the HI/LO unit (≥1)
DIV_CYCLES, 32, cycles a div/divu occupies the HI/LO unit (≥MUL_CYCLES)

Ports:
clk  in  1  core clock
rst_n  in  1  synchronous active-low reset
id_rs  in  5  rs of instruction in ID
id_rt  in  5  rt of instruction in ID
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
id_hilo_read  in  1  ID instruction is mfhi/mflo
id_muldiv  in  1  ID instruction is mult/multu/div/divu
ex_rd  in  5  destination of EX instruction
ex_regwrite  in  1  EX instruction writes the register file
ex_memtoreg  in  1  EX instruction is a load
ex_muldiv_start  in  1  EX instruction is mult/div (one-cycle pulse)
ex_is_div  in  1  qualifies ex_muldiv_start: 1 = div, 0 = mult
ex_branch_taken  in  1  branch/jump resolved taken in EX
mem_rd  in  5  destination of MEM instruction
mem_regwrite  in  1  MEM instruction writes the register file
pc_en  out  1  PC update enable
ifid_en  out  1  IF/ID register enable
ifid_flush  out  1  IF/ID clear to NOP
idex_flush  out  1  ID/EX clear to bubble
ex_fwd_a  out  2  EX operand A mux select
ex_fwd_b  out  2  EX operand B mux select
muldiv_busy  out  1  HI/LO unit occupied
stall_cycles  out  32  stall cycle count (see Optional Feature)

Behaviour:
- **Forward select encoding:** 0 = register-file value, 1 = WB result, 2 = MEM ALU result. Value 3 is never driven.
- **Reset:** on a clk edge with rst_n=0, ex_fwd_a/b=0, muldiv counter=0, stall_cycles=0. The combinational outputs then evaluate with busy=0.
- **Forwarding, computed in ID and registered into EX:**
  - fwd_a_next = 2 if ex_regwrite && ex_rd!=0 && ex_rd==id_rs && id_uses_rs.
  - Else 1 if mem_regwrite && mem_rd!=0 && mem_rd==id_rs && id_uses_rs.
  - Else 0.
  - Same rule for B using id_rt / id_uses_rt.
  - EX-stage match has priority (newer producer).
- **Forward register update on each edge:**
  - idex_flush=1 → ex_fwd_a/b ← 0.
  - Otherwise → ← fwd_next.
  - Latency: 1 cycle, aligned with the ID/EX register.
- **load_use:** ex_memtoreg && ex_regwrite && ex_rd!=0 && ((id_uses_rs && ex_rd==id_rs) || (id_uses_rt && ex_rd==id_rt)). This stalls exactly 1 cycle. The load then sits in MEM, and the re-evaluated forward selects 1 (WB) on the following edge.
- **Mult/div counter:**
  - Idle when cnt==0.
  - ex_muldiv_start → cnt ← (ex_is_div ? DIV_CYCLES : MUL_CYCLES).
  - Otherwise, if cnt!=0, cnt decrements by 1.
  - muldiv_busy = (cnt!=0).
  - Counter width = $clog2(DIV_CYCLES+1).
  - A start pulse while busy cannot occur because of the stall rule; if one does occur, the counter reloads.
- **hilo_stall:** (id_hilo_read || id_muldiv) && (muldiv_busy || ex_muldiv_start).
- **stall** = load_use || hilo_stall.
- **Enables and flushes:**
  - pc_en = ifid_en = !stall || ex_branch_taken.
  - ifid_flush = ex_branch_taken.
  - idex_flush = ex_branch_taken || stall.
- **Branch priority:** ex_branch_taken overrides a simultaneous stall. The younger ID instruction is flushed, so its hazard is moot. The mult/div counter keeps running regardless of flush.
- **No-forward cases:** register $0 never matches. Simultaneous matches in EX and MEM select EX-stage forwarding (2).

Optional Feature:
- Macro: UMIPS_HAZ_PERF_CNT_EN.
- **Defined:**
  - stall_cycles increments on every cycle with stall=1 and ex_branch_taken=0.
  - It saturates at 32'hFFFF_FFFF.
  - It clears on reset.
- **Undefined:** stall_cycles is tied to 0 and no counter flops are generated.

Decomposition:
- **Shared package umips_pkg:**
  - localparams FWD_RF=2'd0, FWD_WB=2'd1, FWD_MEM=2'd2.
  - Register address width REG_AW=5.
- **Sub-module umips_muldiv_timer:**
  - Parameterised countdown counter with load / decrement.
  - Outputs busy.
  - Instantiated once.
- Forwarding compare logic is a local function, not a sub-module.

Test Plan:
- **Forward from EX:** add $3 in EX (ex_rd=3, ex_regwrite=1), ID uses rs=3 → after the edge ex_fwd_a=2, ex_fwd_b=0, pc_en=1.
- **Load-use:** lw $5 in EX (ex_memtoreg=1, ex_rd=5), ID rt=5 uses_rt=1 → pc_en=0, ifid_en=0, idex_flush=1 for exactly 1 cycle. Next cycle, with the load in MEM (mem_rd=5), ex_fwd_b latches 1.
- **$0 and priority:**
  - ex_rd=0 with regwrite, ID rs=0 → ex_fwd_a=0.
  - ex_rd=mem_rd=7, ID rs=7 → ex_fwd_a=2.
- **Divide occupancy:** ex_muldiv_start=1, ex_is_div=1, then mfhi in ID → muldiv_busy=1 for 32 cycles. pc_en=0 during the start cycle and the following 32 cycles. pc_en returns to 1 when cnt reaches 0. With the macro defined, stall_cycles=33.
- **Branch during stall:** load_use=1 and ex_branch_taken=1 in the same cycle → pc_en=1, ifid_flush=1, idex_flush=1, ex_fwd_a/b←0.
- **Reset mid-divide:** rst_n=0 on cycle 10 of a divide → next edge muldiv_busy=0, ex_fwd_a/b=0, stall_cycles=0, pc_en=1.
